// File: rtl/prefetch_linear_tracker_pkg.sv
// Shared definitions for the linear prefetch pointer tracker: state encodings,
// the default line size, and the width of byte-count fields.
package prefetch_linear_tracker_pkg;

  localparam int unsigned PLT_LINE_BYTES = 16;
  localparam int unsigned PLT_LEN_W      = 5;   // holds 0..PLT_LINE_BYTES

  typedef enum logic [1:0] {
    PLT_IDLE        = 2'd0,
    PLT_RUN         = 2'd1,
    PLT_LIMIT_PULSE = 2'd2,
    PLT_STOPPED     = 2'd3
  } plt_state_t;

endpackage

// File: rtl/prefetch_length_calc.sv
// Combinational minimum of a short byte count and a wide byte count.
// Used both to bound a request by line/segment room and to clamp a delivery
// count to what was actually requestable.
//   line_left  in  short count (bytes left in the line, or a delivered count)
//   seg_left   in  wide count (bytes left in the segment, or the request size)
//   length     out min(line_left, seg_left)
module prefetch_length_calc
  import prefetch_linear_tracker_pkg::*;
(
  input  logic [PLT_LEN_W-1:0] line_left,
  input  logic [32:0]          seg_left,
  output logic [PLT_LEN_W-1:0] length
);

  always_comb begin
    if (33'(line_left) <= seg_left) length = line_left;
    else                            length = PLT_LEN_W'(seg_left);
  end

endmodule

// File: rtl/prefetch_linear_tracker.sv
// Tracks the linear instruction-fetch pointer and bytes left before the CS
// limit, presents the prefetch request, and raises a one-cycle limit-fault
// marker pulse when the segment is exhausted.
//   clk, rst                 clock, async active-high reset
//   pr_reset                 flush/redirect: reload from cs_base/cs_limit/eip/cpl
//   cs_base, cs_limit, eip   segment base, inclusive limit, new instruction pointer
//   cpl                      current privilege level
//   prefetched_do/_length    bytes accepted into the prefetch fifo this cycle
//   prefetch_address/_length/_su   request to prefetch control
//   limit_signal_do          fifo must enqueue the limit-fault marker
module prefetch_linear_tracker
  import prefetch_linear_tracker_pkg::*;
#(
  parameter int unsigned LINE_BYTES = PLT_LINE_BYTES  // power of two, <= 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pr_reset,
  input  logic [31:0] cs_base,
  input  logic [31:0] cs_limit,
  input  logic [31:0] eip,
  input  logic [1:0]  cpl,
  input  logic        prefetched_do,
  input  logic [4:0]  prefetched_length,
  output logic [31:0] prefetch_address,
  output logic [4:0]  prefetch_length,
  output logic        prefetch_su,
  output logic        limit_signal_do
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);

  plt_state_t  state;
  logic [31:0] linear;
  logic [32:0] remaining;
  logic        su;

  logic [4:0]  line_left;
  logic [4:0]  run_len;
  logic [4:0]  n;
  logic [32:0] reload_remaining;
  logic [32:0] remaining_after;

  // Bytes from the pointer up to the next line boundary (1..LINE_BYTES).
  assign line_left = 5'(LINE_BYTES) - 5'(linear[OFF_W-1:0]);

  prefetch_length_calc u_len_calc (
    .line_left (line_left),
    .seg_left  (remaining),
    .length    (run_len)
  );

  // A delivery can never advance past what was offered this cycle.
  prefetch_length_calc u_clamp_calc (
    .line_left (prefetched_length),
    .seg_left  ({28'd0, prefetch_length}),
    .length    (n)
  );

  // Limit is inclusive, so a full 4 GiB segment needs the 33rd bit.
  assign reload_remaining = (eip > cs_limit) ? 33'd0
                          : {1'b0, cs_limit} - {1'b0, eip} + 33'd1;
  assign remaining_after  = remaining - 33'(n);

  assign prefetch_address = linear;
  assign prefetch_su      = su;
  assign prefetch_length  = (state == PLT_RUN) ? run_len : 5'd0;
  assign limit_signal_do  = (state == PLT_LIMIT_PULSE);

  // Pointer, segment budget and state; a redirect overrides everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PLT_IDLE;
      linear    <= 32'd0;
      remaining <= 33'd0;
      su        <= 1'b0;
    end else if (pr_reset) begin
      linear    <= cs_base + eip;
      su        <= (cpl == 2'd3);
      remaining <= reload_remaining;
      state     <= (reload_remaining != 33'd0) ? PLT_RUN : PLT_LIMIT_PULSE;
    end else begin
      unique case (state)
        PLT_RUN: begin
          if (prefetched_do) begin
            linear    <= linear + 32'(n);
            remaining <= remaining_after;
            if (remaining_after == 33'd0) state <= PLT_LIMIT_PULSE;
          end
        end
        PLT_LIMIT_PULSE: state <= PLT_STOPPED;
        default:         state <= state;
      endcase
    end
  end

endmodule

// File: doc/prefetch_linear_tracker.md
# prefetch_linear_tracker

Tracks the linear instruction-fetch pointer and the bytes remaining before the CS segment limit, and presents the prefetch request to the prefetch control stage. It sits directly upstream of prefetch control: its `prefetch_address`/`prefetch_length`/`prefetch_su` outputs drive that stage's inputs. The icache-to-fifo path reports delivered bytes back to it. On a branch or flush it reloads from CS base + EIP and signals a limit fault marker once the segment is exhausted.

## Interface
Parameters:
- `LINE_BYTES`, 16: maximum request length; requests never cross a LINE_BYTES-aligned boundary.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `pr_reset`  in  1  flush/redirect; reload the pointer from the CS and EIP inputs
- `cs_base`  in  32  CS segment base, sampled on `pr_reset`
- `cs_limit`  in  32  CS effective byte limit (inclusive), sampled on `pr_reset`
- `eip`  in  32  new instruction pointer, sampled on `pr_reset`
- `cpl`  in  2  current privilege level, sampled on `pr_reset`
- `prefetched_do`  in  1  bytes were accepted into the prefetch fifo this cycle
- `prefetched_length`  in  5  count of accepted bytes, 1..LINE_BYTES
- `prefetch_address`  out  32  current linear fetch address
- `prefetch_length`  out  5  bytes requestable now, 0..LINE_BYTES
- `prefetch_su`  out  1  user-mode fetch (`cpl == 3`)
- `limit_signal_do`  out  1  one-cycle pulse: fifo must enqueue the limit-fault marker

## Operation
- Registers:
  - `linear[31:0]`
  - `remaining[32:0]`: bytes until the limit, up to 2^32
  - `su`
  - `state[1:0]`
- States:
  - IDLE: after reset, until the first `pr_reset`.
  - RUN: fetching.
  - LIMIT_PULSE: a single cycle.
  - STOPPED: waits for `pr_reset`.
- `pr_reset` in any state, highest priority:
  - `linear <= cs_base + eip` (mod 2^32).
  - `su <= (cpl == 2'd3)`.
  - `remaining <= (eip > cs_limit) ? 0 : {1'b0,cs_limit} - eip + 1`.
  - Next state is RUN if the computed `remaining != 0`, else LIMIT_PULSE.
  - A `prefetched_do` in the same cycle is ignored.
- RUN, `prefetched_do` and no `pr_reset`:
  - `n = min(prefetched_length, prefetch_length)`. The RTL clamps; the bench flags any n mismatch as an error.
  - `linear <= linear + n` (wraps mod 2^32).
  - `remaining <= remaining - n`.
  - If the new `remaining == 0`, go to LIMIT_PULSE.
- `prefetch_length`:
  - In RUN: `min(LINE_BYTES - linear[3:0], remaining)`, evaluated on 33-bit `remaining`.
  - In any other state: 0.
- `limit_signal_do`:
  - 1 only in LIMIT_PULSE; that state then goes to STOPPED.
  - A `pr_reset` during LIMIT_PULSE still produces the pulse that cycle, then reloads.
- `prefetched_do` outside RUN is ignored.
- `prefetch_address = linear`, `prefetch_su = su` in all states.

## Timing
- Reset values:
  - `linear = 0`, `remaining = 0`, `su = 0`, state IDLE.
  - Outputs: `prefetch_address = 0`, `prefetch_length = 0`, `prefetch_su = 0`, `limit_signal_do = 0`.
- Outputs are combinational from registers only; there is no input-to-output combinational path.
- Latency:
  - `pr_reset` in cycle T gives new address/length valid in T+1.
  - Delivery in cycle T gives the advanced pointer in T+1.
- Limit exhaustion: the last delivery in cycle T produces `limit_signal_do` in T+1 and `prefetch_length = 0` from T+1.
- `rst` asserted mid-operation returns every register to its reset value immediately. Nothing is retained.

## Structure
- Shared package holds:
  - state encodings `PLT_IDLE=0`, `PLT_RUN=1`, `PLT_LIMIT_PULSE=2`, `PLT_STOPPED=3`
  - `LINE_BYTES`
- One sub-module, `prefetch_length_calc`: combinational min of line-remaining and segment-remaining. It is reused for both the output length and the clamp of n.

## Test plan
- Reset then `pr_reset` with `cs_base=0x000F0000`, `eip=0xFFF0`, `cs_limit=0xFFFF`, `cpl=0`:
  - next cycle: `prefetch_address=0x000FFFF0`, `prefetch_length=16`, `su=0`
  - after one delivery of 16: length 0, `limit_signal_do` pulses once, then STOPPED.
- `eip=0x1005`, `base=0`, `limit=0xFFFFFFFF`, `cpl=3`:
  - length 11 (line boundary), `su=1`
  - after delivering 11: address `0x1010`, length 16.
- `eip=0x20`, `limit=0x22`:
  - length 3
  - delivering 2 gives length 1; delivering 1 gives the pulse.
- `eip > cs_limit` on `pr_reset`: LIMIT_PULSE next cycle, length 0, `linear` still loaded.
- Same-cycle `pr_reset` and `prefetched_do`: the reload wins and the delivery is discarded.
- `base=0xFFFFFFF8`, `eip=0`, `limit=0xFFFFFFFF`:
  - length 8
  - after delivering 8: address wraps to `0x00000000`, length 16, `remaining = 2^32 - 8`.
